// File: rtl/lfsr9_checker_pkg.sv
// Shared constants and types for the 9-bit LFSR lock checker.
// Also imported by the generator side for the seed and width.
package lfsr9_checker_pkg;

    localparam int LFSR9_W = 9;
    localparam logic [LFSR9_W-1:0] LFSR9_SEED = 9'd123;
    localparam int ERR_CNT_W = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/lfsr9_checker_if.sv
// Sample stream in, lock/error status out.
// master drives samples, slave is the checker.
interface lfsr9_checker_if;
    import lfsr9_checker_pkg::*;

    logic                 in_valid;
    logic [LFSR9_W-1:0]   in_data;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    logic [1:0]           state_o;

    modport master (
        output in_valid,
        output in_data,
        input  locked,
        input  err_pulse,
        input  err_count,
        input  state_o
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output locked,
        output err_pulse,
        output err_count,
        output state_o
    );

endinterface

// File: rtl/lfsr9_checker_next.sv
// Next-value function of the 9-bit generator.
// Zero is not a trap state: it restarts from the seed.
module lfsr9_next
    import lfsr9_checker_pkg::*;
(
    input  logic [LFSR9_W-1:0] cur,
    output logic [LFSR9_W-1:0] nxt
);

    logic fb;

    assign fb = cur[8] ^ (cur[7:0] == 8'd0);

    // Shift left with a tap into bit 4; zero maps to the seed.
    always_comb begin
        nxt = {cur[7:4], cur[3] ^ fb, cur[2:0], fb};
        if (cur == '0) begin
            nxt = LFSR9_SEED;
        end
    end

endmodule

// File: rtl/lfsr9_checker.sv
// Locks onto a 9-bit LFSR stream, then flywheels and counts errors.
// All outputs are registered and follow a sample by one cycle.
module lfsr9_checker
    import lfsr9_checker_pkg::*;
#(
    parameter int LOCK_MATCHES    = 4,
    parameter int LOSS_MISMATCHES = 3
) (
    input logic            clk,
    input logic            rst_n,
    lfsr9_checker_if.slave bus
);

    localparam logic [1:0] HUNT   = ST_HUNT;
    localparam logic [1:0] VERIFY = ST_VERIFY;
    localparam logic [1:0] LOCKED = ST_LOCKED;

    localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_MATCHES);
    localparam logic [CNT_W-1:0] LOSS_N = CNT_W'(LOSS_MISMATCHES);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic [1:0]           state;
    logic [LFSR9_W-1:0]   ref_q;
    logic [LFSR9_W-1:0]   pred;
    logic [CNT_W-1:0]     match_cnt;
    logic [CNT_W-1:0]     miss_cnt;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 hit;

    lfsr9_next u_next (
        .cur (ref_q),
        .nxt (pred)
    );

    assign hit = (bus.in_data == pred);

    // Hunt / verify / locked tracker with flywheel prediction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            ref_q     <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (state == 2'd3) begin
                state <= HUNT;
            end else if (bus.in_valid) begin
                case (state)
                    HUNT: begin
                        ref_q     <= bus.in_data;
                        match_cnt <= '0;
                        state     <= VERIFY;
                    end
                    VERIFY: begin
                        ref_q <= bus.in_data;
                        if (hit) begin
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt + 1'b1 == LOCK_N) begin
                                state    <= LOCKED;
                                miss_cnt <= '0;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        ref_q <= pred;
                        if (hit) begin
                            miss_cnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            miss_cnt  <= miss_cnt + 1'b1;
                            if (err_cnt != ERR_MAX) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                            if (miss_cnt + 1'b1 == LOSS_N) begin
                                state <= HUNT;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.locked    = (state == LOCKED);
    assign bus.err_pulse = err_pulse;
    assign bus.err_count = err_cnt;
    assign bus.state_o   = state;

endmodule

// File: tb/tb_lfsr9_checker.sv
// Directed bench for lfsr9_checker with a scoreboard of expected
// outputs pushed per driven cycle and checked one cycle later.
module tb_lfsr9_checker;

    typedef struct packed {
        logic        locked;
        logic        pulse;
        logic [15:0] cnt;
        logic [1:0]  st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    lfsr9_checker_if bus ();

    lfsr9_checker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    logic [1:0]  m_st;
    logic [8:0]  m_ref;
    int          m_match;
    int          m_miss;
    logic [15:0] m_err;
    logic        m_pulse;
    logic [8:0]  g;

    function automatic logic [8:0] nf(input logic [8:0] q);
        logic f;
        if (q == 9'd0) return 9'd123;
        f = q[8] ^ (q[7:0] == 8'd0);
        return {q[7], q[6], q[5], q[4], q[3] ^ f, q[2], q[1], q[0], f};
    endfunction

    task automatic drive(input logic r, input logic v, input logic [8:0] d);
        logic [8:0] p;
        rst_n = r;
        bus.in_valid = v;
        bus.in_data = d;
        if (!r) begin
            m_st = 2'd0; m_ref = 9'd0; m_match = 0;
            m_miss = 0; m_err = 16'd0; m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (v) begin
                case (m_st)
                    2'd0: begin
                        m_ref = d; m_match = 0; m_st = 2'd1;
                    end
                    2'd1: begin
                        if (d == nf(m_ref)) begin
                            m_match++;
                            if (m_match == 4) begin
                                m_st = 2'd2; m_miss = 0;
                            end
                        end else begin
                            m_match = 0;
                        end
                        m_ref = d;
                    end
                    default: begin
                        p = nf(m_ref);
                        m_ref = p;
                        if (d == p) begin
                            m_miss = 0;
                        end else begin
                            m_pulse = 1'b1;
                            if (m_err != 16'hFFFF) m_err++;
                            m_miss++;
                            if (m_miss == 3) m_st = 2'd0;
                        end
                    end
                endcase
            end
        end
        sbq.push_back('{locked: (m_st == 2'd2), pulse: m_pulse,
                        cnt: m_err, st: m_st});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sbq.pop_front();
            checks++;
            assert (bus.locked === e.locked) else begin
                errors++;
                $error("FAIL %s locked got %0b exp %0b", tag, bus.locked, e.locked);
            end
            checks++;
            assert (bus.err_pulse === e.pulse) else begin
                errors++;
                $error("FAIL %s err_pulse got %0b exp %0b", tag, bus.err_pulse, e.pulse);
            end
            checks++;
            assert (bus.err_count === e.cnt) else begin
                errors++;
                $error("FAIL %s err_count got %h exp %h", tag, bus.err_count, e.cnt);
            end
            checks++;
            assert (bus.state_o === e.st) else begin
                errors++;
                $error("FAIL %s state_o got %0d exp %0d", tag, bus.state_o, e.st);
            end
        end
    endtask

    task automatic cyc(input string tag, input logic r, input logic v,
                       input logic [8:0] d);
        drive(r, v, d);
        tick();
        chk(tag);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = 9'd0;
        cyc("rst0", 1'b0, 1'b0, 9'd0);
        cyc("rst_busy", 1'b0, 1'b1, 9'd77);

        g = 9'd123;
        cyc("hunt123", 1'b1, 1'b1, g);
        for (int i = 0; i < 3; i++) begin
            g = nf(g);
            cyc("verify", 1'b1, 1'b1, g);
        end
        checks++;
        assert (bus.state_o === 2'd1 && bus.locked === 1'b0) else begin
            errors++;
            $error("FAIL prelock state %0d locked %0b exp 1/0", bus.state_o, bus.locked);
        end
        g = nf(g);
        cyc("lock", 1'b1, 1'b1, g);
        checks++;
        assert (bus.locked === 1'b1) else begin
            errors++;
            $error("FAIL lock5 locked got %0b exp 1", bus.locked);
        end
        g = nf(g);
        cyc("locked6", 1'b1, 1'b1, g);

        g = nf(g);
        cyc("corrupt", 1'b1, 1'b1, g ^ 9'h155);
        g = nf(g);
        cyc("recover", 1'b1, 1'b1, g);
        cyc("gap0", 1'b1, 1'b0, 9'h1FF);
        cyc("gap1", 1'b1, 1'b0, 9'h000);
        for (int i = 0; i < 3; i++) begin
            g = nf(g);
            cyc("lk_valid", 1'b1, 1'b1, g);
            cyc("lk_gap", 1'b1, 1'b0, g ^ 9'h0AA);
        end

        for (int i = 0; i < 3; i++) begin
            g = nf(g);
            cyc("miss", 1'b1, 1'b1, g ^ 9'h0F0);
        end
        checks++;
        assert (bus.locked === 1'b0 && bus.err_count === 16'd4) else begin
            errors++;
            $error("FAIL loss locked %0b cnt %0d exp 0/4", bus.locked, bus.err_count);
        end

        cyc("hunt5", 1'b1, 1'b1, 9'd5);
        cyc("zero", 1'b1, 1'b1, 9'd0);
        cyc("z2seed", 1'b1, 1'b1, 9'd123);
        g = 9'd123;
        for (int i = 0; i < 3; i++) begin
            cyc("rl_gap", 1'b1, 1'b0, 9'd0);
            g = nf(g);
            cyc("rl_valid", 1'b1, 1'b1, g);
        end

        force dut.err_cnt = 16'hFFFF;
        m_err = 16'hFFFF;
        g = nf(g);
        drive(1'b1, 1'b1, g ^ 9'h001);
        tick();
        release dut.err_cnt;
        chk("sat");
        g = nf(g);
        cyc("sat2", 1'b1, 1'b1, g ^ 9'h001);
        g = nf(g);
        cyc("sat_ok", 1'b1, 1'b1, g);

        g = nf(g);
        cyc("rst_lock", 1'b0, 1'b1, g);
        cyc("post_rst", 1'b1, 1'b1, 9'd300);
        cyc("post_v", 1'b1, 1'b1, nf(9'd300));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
